midi_note_tracker: RTL and testbench

- Sits directly downstream of the MIDI UART/message assembler.
- Consumes the 24-bit {status, data1, data2} word and its 1-cycle ready pulse.
- Maintains a last-note-priority note stack and drives a monophonic NOTE / VELOCITY / GATE interface for the synth voice.
- Filters by MIDI channel and handles Note On, Note Off (including Note On with velocity 0) and All Notes Off.

---
 rtl/midi_note_tracker_pkg.sv | 15 +
 rtl/midi_note_tracker_note_stack.sv | 34 +++
 rtl/midi_note_tracker.sv | 131 +++++++++++++
 tb/tb_midi_note_tracker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_note_tracker_pkg.sv
// midi_note_tracker_pkg: MIDI status constants and tracker FSM encoding
package midi_note_tracker_pkg;
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON = 4'h9;
  localparam logic [3:0] ST_CTRL = 4'hB;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SEARCH,
    S_SHIFT,
    S_PUSH,
    S_UPDATE
  } state_e;
endpackage

// File: rtl/midi_note_tracker_note_stack.sv
// midi_note_tracker_note_stack: last-note-priority storage; e[count-1] is the newest entry
module midi_note_tracker_note_stack #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic          dec_i,
  input  logic          push_i,
  input  logic [IW-1:0] idx_i,
  input  logic [6:0]    note_i,
  output logic [CW-1:0] count_o,
  output logic [6:0]    rd_o,
  output logic [6:0]    top_o
);
  logic [6:0] e_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = clr_i ? '0 : push_i ? count_q + 1'b1 : dec_i ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else count_q <= count_d;
  end
  // Entries are never reset; only indices below count are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (push_i) e_q[IW'(count_q)] <= note_i;
    else if (shift_i) e_q[idx_i] <= e_q[IW'(idx_i + 1'b1)];
  end
  assign count_o = count_q;
  assign rd_o = e_q[idx_i];
  assign top_o = e_q[IW'(count_q - 1'b1)];
endmodule

// File: rtl/midi_note_tracker.sv
// midi_note_tracker: monophonic last-note-priority MIDI note tracker driving NOTE/VELOCITY/GATE
module midi_note_tracker
  import midi_note_tracker_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int OMNI = 0,
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] MIDI_MSG,
  input  logic        MIDI_MSG_RDY,
  output logic [6:0]  NOTE,
  output logic [6:0]  VELOCITY,
  output logic        GATE,
  output logic        NOTE_CHG,
  output logic        BUSY
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic on_q, on_d;
  logic [7:0] stat_q;
  logic [6:0] key_q, val_q, note_q, vel_q;
  logic gate_q, chg_q;
  logic clr, shift, dec, push;
  logic [CW-1:0] count;
  logic [6:0] rd, top;
  logic ch_ok, is_on, is_off, is_all;
  logic unused_bits;
  assign unused_bits = ^{MIDI_MSG[15], MIDI_MSG[7]};
  midi_note_tracker_note_stack #(.DEPTH(DEPTH)) u_stack (
    .clk    (CLK),
    .rst    (RST),
    .clr_i  (clr),
    .shift_i(shift),
    .dec_i  (dec),
    .push_i (push),
    .idx_i  (idx_q),
    .note_i (key_q),
    .count_o(count),
    .rd_o   (rd),
    .top_o  (top)
  );
  always_comb begin
    ch_ok = (OMNI != 0) || (stat_q[3:0] == 4'(CHANNEL));
    is_on = (stat_q[7:4] == ST_NOTE_ON) && (val_q != '0);
    is_off = (stat_q[7:4] == ST_NOTE_OFF) || ((stat_q[7:4] == ST_NOTE_ON) && (val_q == '0));
    is_all = (stat_q[7:4] == ST_CTRL) && (key_q == CC_ALL_NOTES_OFF);
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    on_d = on_q;
    clr = 1'b0;
    shift = 1'b0;
    dec = 1'b0;
    push = 1'b0;
    case (state_q)
      S_IDLE: state_d = MIDI_MSG_RDY ? S_DECODE : S_IDLE;
      S_DECODE: begin
        on_d = is_on;
        idx_d = '0;
        clr = ch_ok && is_all;
        state_d = !ch_ok ? S_IDLE : (is_on || is_off) ? S_SEARCH : is_all ? S_UPDATE : S_IDLE;
      end
      S_SEARCH: begin
        if (count != '0 && rd == key_q) state_d = S_SHIFT;
        else if (count == '0 || CW'(idx_q) == count - 1'b1) state_d = on_q ? S_PUSH : S_UPDATE;
        else idx_d = idx_q + 1'b1;
      end
      // Close the gap at idx one entry per cycle, then drop the stale top.
      S_SHIFT: begin
        if (CW'(idx_q) + 1'b1 < count) begin
          shift = 1'b1;
          idx_d = idx_q + 1'b1;
        end else begin
          dec = 1'b1;
          state_d = on_q ? S_PUSH : S_UPDATE;
        end
      end
      S_PUSH: begin
        if (count == CW'(DEPTH)) begin
          idx_d = '0;
          state_d = S_SHIFT;
        end else begin
          push = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      on_q <= 1'b0;
      stat_q <= '0;
      key_q <= '0;
      val_q <= '0;
      note_q <= '0;
      vel_q <= '0;
      gate_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      on_q <= on_d;
      chg_q <= 1'b0;
      if (state_q == S_IDLE && MIDI_MSG_RDY) begin
        stat_q <= MIDI_MSG[23:16];
        key_q <= MIDI_MSG[14:8];
        val_q <= MIDI_MSG[6:0];
      end
      if (state_q == S_UPDATE) begin
        gate_q <= count != '0;
        if (count != '0) note_q <= top;
        if (on_q) vel_q <= val_q;
        chg_q <= on_q || (gate_q && (count == '0 || top != note_q));
      end
    end
  end
  assign NOTE = note_q;
  assign VELOCITY = vel_q;
  assign GATE = gate_q;
  assign NOTE_CHG = chg_q;
  assign BUSY = state_q != S_IDLE;
endmodule

// File: tb/tb_midi_note_tracker.sv
// tb_midi_note_tracker: randomized and directed checks against a queue-based note-stack model
module tb_midi_note_tracker;
  localparam int DEPTH = 8;
  localparam int LAT = 2 * DEPTH + 5;
  localparam int LIM = 4 * DEPTH + 10;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b0, rdy2 = 1'b0;
  logic [23:0] msg = '0;
  logic [6:0] note, vel, note2, vel2;
  logic gate, chg, busy, gate2, chg2, busy2;
  int asserts = 0, fails = 0;
  int stk[$];
  int m_note = 0, m_vel = 0;
  bit m_gate = 1'b0;
  midi_note_tracker #(.CHANNEL(0), .OMNI(0), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .MIDI_MSG(msg), .MIDI_MSG_RDY(rdy),
    .NOTE(note), .VELOCITY(vel), .GATE(gate), .NOTE_CHG(chg), .BUSY(busy)
  );
  midi_note_tracker #(.CHANNEL(0), .OMNI(1), .DEPTH(DEPTH)) dut_omni (
    .CLK(clk), .RST(rst), .MIDI_MSG(msg), .MIDI_MSG_RDY(rdy2),
    .NOTE(note2), .VELOCITY(vel2), .GATE(gate2), .NOTE_CHG(chg2), .BUSY(busy2)
  );
  always #5 clk = ~clk;
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic model_reset();
    stk.delete();
    m_note = 0;
    m_vel = 0;
    m_gate = 1'b0;
  endtask
  // Reference: channel-0 tracker as a list of held notes, newest last.
  task automatic model(input logic [23:0] m, output int chg_exp);
    int key, v, pos, old_n;
    bit old_g, on;
    logic [3:0] hi;
    hi = m[23:20];
    key = int'(m[14:8]);
    v = int'(m[6:0]);
    old_g = m_gate;
    old_n = m_note;
    chg_exp = 0;
    pos = -1;
    on = (hi == 4'h9) && (v != 0);
    if (m[19:16] != 4'd0) return;
    for (int i = 0; i < stk.size(); i++) if (stk[i] == key) pos = i;
    if (on) begin
      if (pos >= 0) stk.delete(pos);
      if (stk.size() == DEPTH) stk.delete(0);
      stk.push_back(key);
      m_vel = v;
    end else if (hi == 4'h8 || hi == 4'h9) begin
      if (pos >= 0) stk.delete(pos);
    end else if (hi == 4'hB && key == 123) stk.delete();
    else return;
    m_gate = stk.size() != 0;
    if (m_gate) m_note = stk[stk.size()-1];
    chg_exp = on ? 1 : int'(old_g && (!m_gate || m_note != old_n));
  endtask
  task automatic send(input logic [23:0] m, input bit to2, input bit inj, input logic [23:0] m2,
                      output int lat, output int pulses);
    msg = m;
    if (to2) rdy2 = 1'b1;
    else rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    rdy2 = 1'b0;
    lat = 0;
    pulses = 0;
    while ((to2 ? busy2 : busy) && lat < LIM) begin
      if (to2 ? chg2 : chg) pulses++;
      if (inj && lat == 1) begin
        msg = m2;
        rdy = 1'b1;
      end
      @(negedge clk);
      rdy = 1'b0;
      lat++;
    end
    repeat (3) begin
      if (to2 ? chg2 : chg) pulses++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    asserts++;
    if ({note, vel, gate, chg, busy} !== 17'd0 || {note2, vel2, gate2, chg2, busy2} !== 17'd0) begin
      fails++;
      $display("FAIL reset: note=%0d vel=%0d gate=%0d chg=%0d busy=%0d omni_note=%0d omni_gate=%0d required all 0",
               note, vel, gate, chg, busy, note2, gate2);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask
  task automatic test_note_on();
    int lat, p, ec;
    model(24'h903C64, ec);
    send(24'h903C64, 1'b0, 1'b0, '0, lat, p);
    asserts++;
    if (note !== 7'd60 || vel !== 7'd100 || gate !== 1'b1 || p != 1 || lat > LAT) begin
      fails++;
      $display("FAIL note_on: note=%0d vel=%0d gate=%0d pulses=%0d lat=%0d required 60 100 1 1 lat<=%0d",
               note, vel, gate, p, lat, LAT);
    end
  endtask
  task automatic test_stack_order();
    int lat, p, ec;
    logic [23:0] tbl [4] = '{24'h903C64, 24'h904050, 24'h804000, 24'h803C00};
    foreach (tbl[i]) begin
      model(tbl[i], ec);
      send(tbl[i], 1'b0, 1'b0, '0, lat, p);
      asserts++;
      if (note !== 7'(m_note) || vel !== 7'(m_vel) || gate !== m_gate || p != ec || lat > LAT) begin
        fails++;
        $display("FAIL stack_order[%0d]: note=%0d vel=%0d gate=%0d pulses=%0d lat=%0d required %0d %0d %0d %0d",
                 i, note, vel, gate, p, lat, m_note, m_vel, m_gate, ec);
      end
    end
  endtask
  task automatic test_vel0_absent();
    int lat, p, ec;
    logic [23:0] tbl [4] = '{24'h904321, 24'h904300, 24'h804600, 24'h904680};
    foreach (tbl[i]) begin
      model(tbl[i], ec);
      send(tbl[i], 1'b0, 1'b0, '0, lat, p);
      asserts++;
      if (note !== 7'(m_note) || vel !== 7'(m_vel) || gate !== m_gate || p != ec || lat > LAT) begin
        fails++;
        $display("FAIL vel0_absent[%0d]: note=%0d vel=%0d gate=%0d pulses=%0d required %0d %0d %0d %0d",
                 i, note, vel, gate, p, m_note, m_vel, m_gate, ec);
      end
    end
  endtask
  task automatic test_overflow();
    int lat, p, ec;
    logic [23:0] m;
    for (int i = 0; i < 19; i++) begin
      m = i < 9 ? {8'h90, 1'b0, 7'(40 + i), 8'd50 + 8'(i)} : {8'h80, 1'b0, 7'(48 - (i - 9)), 8'h40};
      model(m, ec);
      send(m, 1'b0, 1'b0, '0, lat, p);
      asserts++;
      if (note !== 7'(m_note) || vel !== 7'(m_vel) || gate !== m_gate || p != ec || lat > LAT) begin
        fails++;
        $display("FAIL overflow[%0d] msg=%h: note=%0d vel=%0d gate=%0d pulses=%0d lat=%0d required %0d %0d %0d %0d",
                 i, m, note, vel, gate, p, lat, m_note, m_vel, m_gate, ec);
      end
    end
  endtask
  task automatic test_channel_all_off();
    int lat, p, ec;
    logic [23:0] tbl [5] = '{24'h913C5A, 24'h901E40, 24'h901F41, 24'h902042, 24'hB07B00};
    foreach (tbl[i]) begin
      model(tbl[i], ec);
      send(tbl[i], 1'b0, 1'b0, '0, lat, p);
      asserts++;
      if (note !== 7'(m_note) || vel !== 7'(m_vel) || gate !== m_gate || p != ec || lat > LAT) begin
        fails++;
        $display("FAIL channel_all_off[%0d]: note=%0d vel=%0d gate=%0d pulses=%0d required %0d %0d %0d %0d",
                 i, note, vel, gate, p, m_note, m_vel, m_gate, ec);
      end
    end
  endtask
  task automatic test_omni();
    int lat, p;
    send(24'h913C5A, 1'b1, 1'b0, '0, lat, p);
    asserts++;
    if (note2 !== 7'd60 || vel2 !== 7'd90 || gate2 !== 1'b1 || p != 1) begin
      fails++;
      $display("FAIL omni: note=%0d vel=%0d gate=%0d pulses=%0d required 60 90 1 1", note2, vel2, gate2, p);
    end
  endtask
  task automatic test_back_to_back();
    int lat, p, ec, d;
    logic [23:0] tbl [4] = '{24'h900A10, 24'h900B11, 24'h900C12, 24'h900D13};
    foreach (tbl[i]) begin
      model(tbl[i], ec);
      send(tbl[i], 1'b0, 1'b0, '0, lat, p);
    end
    model(24'h901420, ec);
    send(24'h901420, 1'b0, 1'b1, 24'h90637F, lat, p);
    asserts++;
    if (note !== 7'(m_note) || vel !== 7'(m_vel) || gate !== m_gate || p != ec || busy !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back: note=%0d vel=%0d gate=%0d pulses=%0d busy=%0d required %0d %0d %0d %0d 0",
               note, vel, gate, p, busy, m_note, m_vel, m_gate, ec);
    end
    model(24'h801400, ec);
    send(24'h801400, 1'b0, 1'b0, '0, lat, p);
    asserts++;
    if (note !== 7'(m_note) || gate !== m_gate || p != ec) begin
      fails++;
      $display("FAIL back_to_back_after: note=%0d gate=%0d pulses=%0d required %0d %0d %0d",
               note, gate, p, m_note, m_gate, ec);
    end
  endtask
  task automatic test_reset_mid();
    int lat, p, ec;
    logic [23:0] tbl [5] = '{24'hB07B00, 24'h900A40, 24'h900B40, 24'h900C40, 24'h900D40};
    foreach (tbl[i]) begin
      model(tbl[i], ec);
      send(tbl[i], 1'b0, 1'b0, '0, lat, p);
    end
    msg = 24'h800A00;
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    asserts++;
    if ({note, vel, gate, chg, busy} !== 17'd0) begin
      fails++;
      $display("FAIL reset_mid: note=%0d vel=%0d gate=%0d chg=%0d busy=%0d required all 0",
               note, vel, gate, chg, busy);
    end
    model(24'h903246, ec);
    send(24'h903246, 1'b0, 1'b0, '0, lat, p);
    asserts++;
    if (note !== 7'd50 || vel !== 7'd70 || gate !== 1'b1 || p != 1 || lat > LAT) begin
      fails++;
      $display("FAIL reset_mid_on: note=%0d vel=%0d gate=%0d pulses=%0d lat=%0d required 50 70 1 1",
               note, vel, gate, p, lat);
    end
  endtask
  task automatic test_random();
    int lat, p, ec, r;
    logic [7:0] d1, d2;
    logic [23:0] m;
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(19, 0);
      d1 = {1'($urandom_range(1, 0)), 7'($urandom_range(47, 36))};
      d2 = {1'($urandom_range(1, 0)), 7'($urandom_range(127, 1))};
      m = r < 9 ? {8'h90, d1, d2} :
          r < 11 ? {8'h90, d1, d2 & 8'h80} :
          r < 16 ? {8'h80, d1, d2} :
          r == 16 ? {8'hB0, d1[7], 7'd123, d2} :
          r == 17 ? {4'h9, 4'($urandom_range(15, 1)), d1, d2} :
          r == 18 ? {8'hB0, 8'd7, d2} : {8'hA0, d1, d2};
      model(m, ec);
      send(m, 1'b0, 1'b0, '0, lat, p);
      asserts++;
      if (note !== 7'(m_note) || vel !== 7'(m_vel) || gate !== m_gate || p != ec || lat > LAT) begin
        fails++;
        $display("FAIL random[%0d] msg=%h: note=%0d vel=%0d gate=%0d pulses=%0d lat=%0d required %0d %0d %0d %0d",
                 t, m, note, vel, gate, p, lat, m_note, m_vel, m_gate, ec);
      end
    end
  endtask
  initial begin
    test_reset();
    test_note_on();
    test_stack_order();
    test_vel0_absent();
    test_overflow();
    test_channel_all_off();
    test_omni();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
